// File: rtl/bcd_double_dabble_seq.sv
// ============================================================================
// Module  : bcd_double_dabble_seq
// Brief   : Sequential binary-to-BCD converter (shift-add-3), sign carried
//           alongside the digits. Optional macro: DD_LEADING_BLANK_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module bcd_double_dabble_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Start,
  input  logic                  i_Signo,
  input  logic [WIDTH-1:0]      i_Val,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Signo,
  output logic [4*DIGITS-1:0]   o_Bcd,
  output logic [DIGITS-1:0]     o_Blank
);

  localparam int SW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD3  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state, w_next;
  logic [SW-1:0]       r_scratch;
  logic [SW-1:0]       w_add3;
  logic [CW-1:0]       r_cnt;
  logic                r_sign_pend;
  logic                r_done;
  logic                r_sign;
  logic [4*DIGITS-1:0] r_bcd;

  // Every nibble is corrected from its pre-add value, so the adders are independent.
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
      logic [3:0] w_nib;
      assign w_nib = r_scratch[WIDTH+4*k +: 4];
      assign w_add3[WIDTH+4*k +: 4] = (w_nib >= 4'd5) ? w_nib + 4'd3 : w_nib;
    end
  endgenerate
  assign w_add3[WIDTH-1:0] = r_scratch[WIDTH-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_Start) w_next = S_ADD3;
      S_ADD3:  w_next = S_SHIFT;
      S_SHIFT: w_next = (r_cnt == CW'(1)) ? S_DONE : S_ADD3;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state     <= S_IDLE;
      r_scratch   <= '0;
      r_cnt       <= '0;
      r_sign_pend <= 1'b0;
      r_done      <= 1'b0;
      r_sign      <= 1'b0;
      r_bcd       <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_Start) begin
            r_scratch   <= {{(4*DIGITS){1'b0}}, i_Val};
            r_sign_pend <= i_Signo;
            r_cnt       <= CW'(WIDTH);
          end
        end
        S_ADD3:  r_scratch <= w_add3;
        S_SHIFT: begin
          r_scratch <= {r_scratch[SW-2:0], 1'b0};
          r_cnt     <= r_cnt - CW'(1);
        end
        S_DONE: begin
          r_bcd  <= r_scratch[SW-1:WIDTH];
          r_sign <= r_sign_pend;
        end
        default: ;
      endcase
    end
  end

`ifdef DD_LEADING_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;
  logic              w_hi_zero;

  // A digit blanks only when it and every digit above it are zero; units never blank.
  always_comb begin
    w_blank   = '0;
    w_hi_zero = 1'b1;
    for (int k = DIGITS-1; k >= 1; k--) begin
      w_hi_zero  = w_hi_zero & (r_scratch[WIDTH+4*k +: 4] == 4'd0);
      w_blank[k] = w_hi_zero;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_blank <= '0;
    end else if (r_state == S_DONE) begin
      r_blank <= w_blank;
    end
  end

  assign o_Blank = r_blank;
`else
  assign o_Blank = '0;
`endif

  assign o_Busy  = (r_state == S_ADD3) || (r_state == S_SHIFT);
  assign o_Done  = r_done;
  assign o_Signo = r_sign;
  assign o_Bcd   = r_bcd;

endmodule

`default_nettype wire

// File: tb/tb_bcd_double_dabble_seq.sv
// ============================================================================
// Module  : tb_bcd_double_dabble_seq
// Brief   : Directed self-checking bench for bcd_double_dabble_seq.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_double_dabble_seq;

  logic        i_Clk;
  logic        i_Rst_n;
  logic        i_Start;
  logic        i_Signo;
  logic [7:0]  i_Val;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Signo;
  logic [11:0] o_Bcd;
  logic [2:0]  o_Blank;

  int checks = 0;
  int errors = 0;

  bcd_double_dabble_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Start (i_Start),
    .i_Signo (i_Signo),
    .i_Val   (i_Val),
    .o_Busy  (o_Busy),
    .o_Done  (o_Done),
    .o_Signo (o_Signo),
    .o_Bcd   (o_Bcd),
    .o_Blank (o_Blank)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  function automatic logic [2:0] exp_blank(input logic [2:0] b);
`ifdef DD_LEADING_BLANK_EN
    return b;
`else
    return 3'b000;
`endif
  endfunction

  task automatic do_start(input logic [7:0] val, input logic sign);
    @(negedge i_Clk);
    i_Val   = val;
    i_Signo = sign;
    i_Start = 1'b1;
    @(posedge i_Clk);
    #1 i_Start = 1'b0;
  endtask

  // Returns cycles from the accepting edge to o_Done (-1 on timeout).
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (o_Busy) busy_cnt++;
      @(posedge i_Clk);
      #1;
      if (o_Done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_Rst_n = 1'b0;
    i_Start = 1'b0;
    i_Signo = 1'b0;
    i_Val   = 8'd0;
    repeat (3) @(posedge i_Clk);
    #1;
    checks++;
    if ({o_Busy, o_Done, o_Signo, o_Bcd, o_Blank} !== 17'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b sign=%b bcd=%h blank=%b, expected all 0",
               o_Busy, o_Done, o_Signo, o_Bcd, o_Blank);
    end
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int lat, bc;
    do_start(8'd0, 1'b0);
    wait_done(lat, bc);
    checks++;
    if (lat !== 17) begin
      errors++; $display("FAIL zero_latency: got %0d, expected 17", lat);
    end
    checks++;
    if (bc !== 16) begin
      errors++; $display("FAIL zero_busy_cycles: got %0d, expected 16", bc);
    end
    checks++;
    if (o_Bcd !== 12'h000 || o_Signo !== 1'b0) begin
      errors++; $display("FAIL zero_result: got bcd=%h sign=%b, expected 000 0", o_Bcd, o_Signo);
    end
    checks++;
    if (o_Blank !== exp_blank(3'b110)) begin
      errors++; $display("FAIL zero_blank: got %b, expected %b", o_Blank, exp_blank(3'b110));
    end
    @(posedge i_Clk);
    #1;
    checks++;
    if (o_Done !== 1'b0) begin
      errors++; $display("FAIL done_one_cycle: got %b, expected 0", o_Done);
    end
  endtask

  task automatic test_values();
    logic [7:0]  vals  [6] = '{8'd255, 8'd128, 8'd0,    8'd7,    8'd99,  8'd40};
    logic        signs [6] = '{1'b0,   1'b1,   1'b1,    1'b0,    1'b1,   1'b0};
    logic [11:0] bcds  [6] = '{12'h255, 12'h128, 12'h000, 12'h007, 12'h099, 12'h040};
    logic [2:0]  blanks[6] = '{3'b000, 3'b000, 3'b110,  3'b110,  3'b100, 3'b100};
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      do_start(vals[i], signs[i]);
      wait_done(lat, bc);
      checks++;
      if (lat !== 17 || o_Bcd !== bcds[i] || o_Signo !== signs[i]) begin
        errors++;
        $display("FAIL value_%0d: got lat=%0d bcd=%h sign=%b, expected lat=17 bcd=%h sign=%b",
                 vals[i], lat, o_Bcd, o_Signo, bcds[i], signs[i]);
      end
      checks++;
      if (o_Blank !== exp_blank(blanks[i])) begin
        errors++;
        $display("FAIL blank_%0d: got %b, expected %b", vals[i], o_Blank, exp_blank(blanks[i]));
      end
    end
  endtask

  task automatic test_ignore_start();
    int first, pulses;
    logic held_ok;
    first = -1; pulses = 0; held_ok = 1'b1;
    do_start(8'd47, 1'b0);
    repeat (4) @(posedge i_Clk);
    @(negedge i_Clk);
    i_Val = 8'd99; i_Signo = 1'b1; i_Start = 1'b1;
    @(posedge i_Clk);
    #1 i_Start = 1'b0;
    for (int c = 6; c <= 50; c++) begin
      if (c < 17 && (o_Bcd !== 12'h040 || o_Signo !== 1'b0)) held_ok = 1'b0;
      @(posedge i_Clk);
      #1;
      if (o_Done) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    checks++;
    if (!held_ok) begin
      errors++; $display("FAIL output_hold: got changing outputs during conversion, expected bcd=040 held");
    end
    checks++;
    if (first !== 17 || pulses !== 1) begin
      errors++; $display("FAIL ignore_start_done: got first=%0d pulses=%0d, expected 17 1", first, pulses);
    end
    checks++;
    if (o_Bcd !== 12'h047 || o_Signo !== 1'b0) begin
      errors++; $display("FAIL ignore_start_result: got bcd=%h sign=%b, expected 047 0", o_Bcd, o_Signo);
    end
  endtask

  task automatic test_reset_mid();
    int pulses, lat, bc;
    pulses = 0;
    do_start(8'd200, 1'b0);
    repeat (7) @(posedge i_Clk);
    #3 i_Rst_n = 1'b0;
    #1;
    checks++;
    if (o_Bcd !== 12'h000 || o_Busy !== 1'b0 || o_Done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got bcd=%h busy=%b done=%b, expected 000 0 0", o_Bcd, o_Busy, o_Done);
    end
    repeat (2) @(posedge i_Clk);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge i_Clk);
      #1;
      if (o_Done || o_Busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL reset_abandon: got %0d active cycles, expected 0", pulses);
    end
    do_start(8'd13, 1'b0);
    wait_done(lat, bc);
    checks++;
    if (lat !== 17 || o_Bcd !== 12'h013) begin
      errors++; $display("FAIL after_reset: got lat=%0d bcd=%h, expected 17 013", lat, o_Bcd);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    @(negedge i_Clk);
    i_Val = 8'd9; i_Signo = 1'b0; i_Start = 1'b1;
    @(posedge i_Clk);
    #1;
    wait_done(lat, bc);
    checks++;
    if (lat !== 17 || o_Bcd !== 12'h009) begin
      errors++; $display("FAIL b2b_first: got lat=%0d bcd=%h, expected 17 009", lat, o_Bcd);
    end
    @(posedge i_Clk);
    #1;
    checks++;
    if (o_Busy !== 1'b1 || o_Done !== 1'b0) begin
      errors++; $display("FAIL b2b_restart: got busy=%b done=%b, expected 1 0", o_Busy, o_Done);
    end
    i_Start = 1'b0;
    wait_done(lat, bc);
    checks++;
    if (lat !== 17 || o_Bcd !== 12'h009) begin
      errors++; $display("FAIL b2b_second: got lat=%0d bcd=%h, expected 17 009", lat, o_Bcd);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_double_dabble_seq.md
Name: bcd_double_dabble_seq

Overview:
Sequential binary-to-BCD converter; consumes the sign/magnitude pair produced by the two's-complement-to-magnitude stage.
Converts the unsigned magnitude to packed BCD with the shift-add-3 (double dabble) algorithm, one add or shift step per clock.
Carries the sign alongside the digits for the downstream 7-segment/display driver.
Start/done handshake; one conversion in flight at a time.

Parameters:
WIDTH, 8, bit width of the input magnitude
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1

Ports:
i_Clk  input  1  system clock, rising edge
i_Rst_n  input  1  asynchronous reset, active-low
i_Start  input  1  request conversion; sampled only in IDLE
i_Signo  input  1  sign from upstream stage (1 = negative)
i_Val  input  WIDTH  unsigned magnitude from upstream stage
o_Busy  output  1  high while in ADD3 or SHIFT
o_Done  output  1  one-cycle pulse when o_Bcd/o_Signo update
o_Signo  output  1  registered sign of the last completed conversion
o_Bcd  output  4*DIGITS  packed BCD; digit 0 (units) in [3:0]
o_Blank  output  DIGITS  leading-zero blank mask (see Optional Feature)

Behaviour:
- One clock. Reset is asynchronous and active-low: i_Rst_n low forces state IDLE, bit counter 0, scratch 0, o_Bcd 0, o_Signo 0, o_Done 0, o_Busy 0, o_Blank 0 immediately, independent of i_Clk.
- FSM states: IDLE, ADD3, SHIFT, DONE.
- IDLE: if i_Start=1 at an edge, capture i_Val into the low WIDTH bits of scratch {bcd[4*DIGITS-1:0], bin[WIDTH-1:0]} and clear the BCD part. Also capture i_Signo into a pending register, load the counter with WIDTH, and go to ADD3. Otherwise stay in IDLE.
- ADD3: for every BCD nibble of scratch >= 5, add 3 to that nibble. All nibbles are evaluated in parallel from the pre-add value. Next state is SHIFT.
- SHIFT: shift the whole scratch left by 1 with zero fill, then decrement the counter. If the counter reaches 0, go to DONE; otherwise go to ADD3.
- DONE: o_Bcd <= BCD part of scratch, o_Signo <= pending sign, o_Done=1 for this cycle only, then go to IDLE.
- Latency: o_Done is high exactly 2*WIDTH+1 cycles after the edge that sampled i_Start; this is 17 cycles for WIDTH=8. Fixed latency, independent of data.
- o_Bcd and o_Signo hold their last completed value between conversions; they do not change during ADD3/SHIFT.
- i_Start is ignored in ADD3, SHIFT and DONE. There is no queueing. The earliest accepted restart is the cycle after DONE, in IDLE.
- i_Val and i_Signo are sampled only on the accepting edge; later changes do not affect the conversion in flight.
- Reset mid-conversion: the conversion is abandoned, outputs go to reset values, and no o_Done pulse is produced.
- Zero magnitude with i_Signo=1 passes through unchanged: o_Signo=1, o_Bcd=0. This block does not suppress the sign.

Optional Feature:
Macro DD_LEADING_BLANK_EN.
- Defined: in DONE, o_Blank[k]=1 for each digit k>0 where that digit and all higher digits of the result are 0. o_Blank[0] is always 0. o_Blank updates together with o_Bcd.
- Not defined: o_Blank is tied to 0 and no blank logic is synthesized.

Test Plan:
- Reset low, then release; i_Start=1 with i_Val=8'd0, i_Signo=0 -> o_Busy high for 16 cycles, o_Done pulses at cycle 17, o_Bcd=12'h000, o_Signo=0.
- i_Val=8'd255 -> o_Bcd=12'h255; i_Val=8'd128 with i_Signo=1 (upstream -128) -> o_Bcd=12'h128, o_Signo=1.
- Start with 8'd47; pulse i_Start with 8'd99 at cycle 5 -> o_Bcd=12'h047, only one o_Done pulse, the second request is ignored.
- Start with 8'd200; assert i_Rst_n=0 at cycle 8 -> o_Bcd=0 and o_Busy=0 immediately, no o_Done afterwards; a new start with 8'd13 -> o_Bcd=12'h013.
- Back-to-back: start 8'd9 and hold i_Start high -> o_Done at cycle 17, next start accepted in IDLE at cycle 18, o_Bcd=12'h009 both times.
- With DD_LEADING_BLANK_EN: i_Val=8'd7 -> o_Blank=3'b110; 8'd40 -> 3'b100; 8'd0 -> 3'b110. Without the macro, o_Blank=0 in all three cases.
